// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the ALU time-sharing arbiter: widths, ALU op codes,
// FSM states and the request/response payload structs.
package alu_share_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 3'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 3'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 3'd3;
  localparam logic [OP_W-1:0] ALU_XOR  = 3'd4;
  localparam logic [OP_W-1:0] ALU_SLT  = 3'd5;
  localparam logic [OP_W-1:0] ALU_SLTU = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Operand register contents
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_req_t;

  // Response register contents
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              lt;
    logic              gte;
  } alu_rsp_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// One requester's request and response channels.
//   master: requester side (drives req_*, rsp_ready)
//   slave : arbiter side   (drives req_ready, rsp_*)
interface alu_share_arb_if;
  import alu_share_arb_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [OP_W-1:0]   req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_lt;
  logic              rsp_gte;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_lt, rsp_gte
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_lt, rsp_gte
  );

endinterface

// File: rtl/ALU.sv
// Combinational 32-bit ALU with compare flags.
//   a, b   : operands
//   op     : operation code (op 7 yields zero)
//   result : operation result, mod 2^32
//   zero   : result == 0
//   lt/gte : unsigned a < b / a >= b
module ALU
  import alu_share_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              lt,
  output logic              gte
);

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = DATA_W'($signed(a) < $signed(b));
      ALU_SLTU: result = DATA_W'(a < b);
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign lt   = (a < b);
  assign gte  = ~lt;

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
//   valid   : request lines
//   advance : a grant was taken this cycle; hand priority to the other side
//   grant   : one-hot grant (combinational)
module rr_arb2 #(
  parameter int unsigned PRIO_RESET = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  // A lone requester wins outright; ptr only breaks ties
  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  // Priority goes to the index that was not granted
  always_ff @(posedge clk) begin
    if (!rst_n)       ptr <= 1'(PRIO_RESET);
    else if (advance) ptr <= grant[0];
  end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one ALU between two requesters: round-robin grant, operand
// register, one EXEC cycle, result held until the owner accepts it.
//   clk, rst_n : clock, synchronous active-low reset
//   p0, p1     : requester channels (req valid/ready/a/b/op, rsp valid/ready/result/flags)
//   busy       : high while in EXEC or RESP
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int unsigned PRIO_RESET = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_share_arb_if.slave  p0,
  alu_share_arb_if.slave  p1,
  output logic            busy
);

  state_e            state_q;
  logic              owner_q;
  alu_req_t          opnd_q;
  alu_rsp_t          rsp_q;
  logic [1:0]        rsp_valid_q;

  logic [1:0]        arb_valid_c;
  logic [1:0]        grant_c;
  logic              handshake_c;
  logic              own_rsp_ready_c;
  alu_req_t          sel_req_c;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_lt;
  logic              alu_gte;

  // Requests are only visible to the arbiter in IDLE and out of reset
  assign arb_valid_c = {p1.req_valid, p0.req_valid}
                     & {2{rst_n && (state_q == ST_IDLE)}};
  assign handshake_c = |grant_c;

  rr_arb2 #(.PRIO_RESET(PRIO_RESET)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (arb_valid_c),
    .advance (handshake_c),
    .grant   (grant_c)
  );

  assign p0.req_ready = grant_c[0];
  assign p1.req_ready = grant_c[1];

  assign sel_req_c = grant_c[1] ? {p1.req_a, p1.req_b, p1.req_op}
                                : {p0.req_a, p0.req_b, p0.req_op};
  assign own_rsp_ready_c = owner_q ? p1.rsp_ready : p0.rsp_ready;

  ALU u_alu (
    .a      (opnd_q.a),
    .b      (opnd_q.b),
    .op     (opnd_q.op),
    .result (alu_result),
    .zero   (alu_zero),
    .lt     (alu_lt),
    .gte    (alu_gte)
  );

  // Sequencer: capture -> evaluate -> hold response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      opnd_q      <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 2'b00;
      busy        <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (handshake_c) begin
            opnd_q  <= sel_req_c;
            owner_q <= grant_c[1];
            state_q <= ST_EXEC;
            busy    <= 1'b1;
          end
        end
        ST_EXEC: begin
          rsp_q       <= {alu_result, alu_zero, alu_lt, alu_gte};
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (own_rsp_ready_c) begin
            rsp_valid_q <= 2'b00;
            state_q     <= ST_IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          state_q     <= ST_IDLE;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Both channels see the shared response register; valid selects the owner
  assign p0.rsp_valid  = rsp_valid_q[0];
  assign p0.rsp_result = rsp_q.result;
  assign p0.rsp_zero   = rsp_q.zero;
  assign p0.rsp_lt     = rsp_q.lt;
  assign p0.rsp_gte    = rsp_q.gte;
  assign p1.rsp_valid  = rsp_valid_q[1];
  assign p1.rsp_result = rsp_q.result;
  assign p1.rsp_zero   = rsp_q.zero;
  assign p1.rsp_lt     = rsp_q.lt;
  assign p1.rsp_gte    = rsp_q.gte;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed vector table, multi-cycle
// corner sequences, then randomized traffic against a transaction-level model.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  always #5 clk = ~clk;

  alu_share_arb_if i0();
  alu_share_arb_if i1();

  alu_share_arb #(.PRIO_RESET(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .p0    (i0),
    .p1    (i1),
    .busy  (busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        z;
    logic        lt;
    logic        gte;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int p, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
    if (p == 0) begin
      i0.req_valid = v; i0.req_a = a; i0.req_b = b; i0.req_op = op;
    end else begin
      i1.req_valid = v; i1.req_a = a; i1.req_b = b; i1.req_op = op;
    end
  endtask

  function automatic logic get_ready(input int p);
    return (p == 0) ? i0.req_ready : i1.req_ready;
  endfunction

  function automatic logic get_rv(input int p);
    return (p == 0) ? i0.rsp_valid : i1.rsp_valid;
  endfunction

  // Owner's response: valid high, other valid low, data and flags as given
  task automatic chk_rsp(input int p, input string name, input logic [31:0] res,
                         input logic z, input logic lt, input logic gte);
    chk({name, "_rv_own"}, 32'(get_rv(p)), 32'd1);
    chk({name, "_rv_other"}, 32'(get_rv(1 - p)), 32'd0);
    if (p == 0) begin
      chk({name, "_result"}, i0.rsp_result, res);
      chk({name, "_flags"}, 32'({i0.rsp_zero, i0.rsp_lt, i0.rsp_gte}), 32'({z, lt, gte}));
    end else begin
      chk({name, "_result"}, i1.rsp_result, res);
      chk({name, "_flags"}, 32'({i1.rsp_zero, i1.rsp_lt, i1.rsp_gte}), 32'({z, lt, gte}));
    end
  endtask

  // Reference ALU from the op-code table: {result, zero, lt, gte}
  function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd6: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {r, r == 32'd0, a < b, a >= b};
  endfunction

  // Single isolated operation on port p with fixed 3-cycle timing
  task automatic run_op(input int p, input vec_t v, input string name);
    drive_req(p, 1'b1, v.a, v.b, v.op);
    i0.rsp_ready = (p == 0);
    i1.rsp_ready = (p == 1);
    @(negedge clk);
    chk({name, "_ready_own"}, 32'(get_ready(p)), 32'd1);
    chk({name, "_ready_other"}, 32'(get_ready(1 - p)), 32'd0);
    chk({name, "_busy_idle"}, 32'(busy), 32'd0);
    next();
    drive_req(p, 1'b0, v.a, v.b, v.op);
    @(negedge clk);
    chk({name, "_busy_exec"}, 32'(busy), 32'd1);
    chk({name, "_rv_exec"}, 32'({i1.rsp_valid, i0.rsp_valid}), 32'd0);
    next();
    @(negedge clk);
    chk_rsp(p, name, v.res, v.z, v.lt, v.gte);
    next();
    @(negedge clk);
    chk({name, "_rv_done"}, 32'({i1.rsp_valid, i0.rsp_valid}), 32'd0);
    chk({name, "_busy_done"}, 32'(busy), 32'd0);
    next();
  endtask

  function automatic logic [31:0] rand_opnd();
    logic [31:0] s;
    s = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return s;
      2: return 32'hFFFF_FFFF - s;
      default: return 32'h8000_0000 ^ s;
    endcase
  endfunction

  // Random-phase stimulus and model state
  logic        mv[2];
  logic [31:0] ma[2];
  logic [31:0] mb[2];
  logic [2:0]  mop[2];
  logic        mrr[2];
  logic        m_ptr;
  int          m_age;
  int          m_owner;
  logic [34:0] m_exp;
  int          grants[$];

  initial begin
    vt[0]  = '{32'd7,          32'd5,          3'd1, 32'd2,          1'b0, 1'b0, 1'b1};
    vt[1]  = '{32'hFFFF_FFFF,  32'd1,          3'd5, 32'd1,          1'b0, 1'b0, 1'b1};
    vt[2]  = '{32'hFFFF_FFFF,  32'd1,          3'd6, 32'd0,          1'b1, 1'b0, 1'b1};
    vt[3]  = '{32'hFFFF_FFFF,  32'd1,          3'd0, 32'd0,          1'b1, 1'b0, 1'b1};
    vt[4]  = '{32'd3,          32'd4,          3'd0, 32'd7,          1'b0, 1'b1, 1'b0};
    vt[5]  = '{32'hF0,         32'h3C,         3'd2, 32'h30,         1'b0, 1'b0, 1'b1};
    vt[6]  = '{32'd9,          32'd4,          3'd7, 32'd0,          1'b1, 1'b0, 1'b1};
    vt[7]  = '{32'h0F,         32'hF0,         3'd3, 32'hFF,         1'b0, 1'b1, 1'b0};
    vt[8]  = '{32'd5,          32'd5,          3'd4, 32'd0,          1'b1, 1'b0, 1'b1};
    vt[9]  = '{32'd1,          32'hFFFF_FFFF,  3'd5, 32'd0,          1'b1, 1'b1, 1'b0};
    vt[10] = '{32'd0,          32'd1,          3'd1, 32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0};
    vt[11] = '{32'h8000_0000,  32'h7FFF_FFFF,  3'd5, 32'd1,          1'b0, 1'b0, 1'b1};

    // Reset with both requesters already valid
    rst_n = 1'b0;
    drive_req(0, 1'b1, 32'd3, 32'd4, 3'd0);
    drive_req(1, 1'b1, 32'hF0, 32'h3C, 3'd2);
    i0.rsp_ready = 1'b1;
    i1.rsp_ready = 1'b1;
    next(); next(); next();
    @(negedge clk);
    chk("rst_ready", 32'({i1.req_ready, i0.req_ready}), 32'd0);
    chk("rst_rsp_valid", 32'({i1.rsp_valid, i0.rsp_valid}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result0", i0.rsp_result, 32'd0);
    chk("rst_result1", i1.rsp_result, 32'd0);
    chk("rst_flags", 32'({i0.rsp_zero, i0.rsp_lt, i0.rsp_gte, i1.rsp_zero, i1.rsp_lt, i1.rsp_gte}), 32'd0);
    next();
    rst_n = 1'b1;

    // Simultaneous requests: req0 first (PRIO_RESET=0), then req1
    @(negedge clk);
    chk("sim_ready_first", 32'({i1.req_ready, i0.req_ready}), 32'b01);
    next();
    drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    chk("sim_exec_ready", 32'({i1.req_ready, i0.req_ready}), 32'd0);
    next();
    @(negedge clk);
    chk_rsp(0, "sim_rsp0", 32'd7, 1'b0, 1'b1, 1'b0);
    chk("sim_resp_ready", 32'({i1.req_ready, i0.req_ready}), 32'd0);
    next();
    @(negedge clk);
    chk("sim_ready_second", 32'({i1.req_ready, i0.req_ready}), 32'b10);
    next();
    drive_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
    next();
    @(negedge clk);
    chk_rsp(1, "sim_rsp1", 32'h30, 1'b0, 1'b0, 1'b1);
    next();
    next();

    // Vector table, alternating ports
    for (int k = 0; k < 12; k++) run_op(k % 2, vt[k], $sformatf("vec%0d", k));

    // Backpressure on rsp1 while req0 waits
    drive_req(1, 1'b1, 32'h1234_5678, 32'd1, 3'd4);
    i1.rsp_ready = 1'b0;
    i0.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready1", 32'({i1.req_ready, i0.req_ready}), 32'b10);
    next();
    drive_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
    drive_req(0, 1'b1, 32'd2, 32'd3, 3'd0);
    @(negedge clk);
    chk("bp_exec_ready", 32'({i1.req_ready, i0.req_ready}), 32'd0);
    for (int k = 0; k < 5; k++) begin
      next();
      @(negedge clk);
      chk_rsp(1, $sformatf("bp_hold%0d", k), 32'h1234_5679, 1'b0, 1'b0, 1'b1);
      chk($sformatf("bp_hold%0d_ready", k), 32'({i1.req_ready, i0.req_ready}), 32'd0);
      chk($sformatf("bp_hold%0d_busy", k), 32'(busy), 32'd1);
    end
    next();
    i1.rsp_ready = 1'b1;
    @(negedge clk);
    chk_rsp(1, "bp_release", 32'h1234_5679, 1'b0, 1'b0, 1'b1);
    next();
    i0.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_rv", 32'({i1.rsp_valid, i0.rsp_valid}), 32'd0);
    chk("bp_idle_ready0", 32'({i1.req_ready, i0.req_ready}), 32'b01);
    next();
    drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    next();
    @(negedge clk);
    chk_rsp(0, "bp_rsp0", 32'd5, 1'b0, 1'b1, 1'b0);
    next();
    next();

    // Reset during EXEC discards the op; ptr (now 1) returns to PRIO_RESET
    drive_req(0, 1'b1, 32'd11, 32'd22, 3'd0);
    @(negedge clk);
    chk("rm_ready0", 32'(i0.req_ready), 32'd1);
    next();
    drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_exec_busy", 32'(busy), 32'd1);
    next();
    @(negedge clk);
    chk("rm_rst_busy", 32'(busy), 32'd0);
    chk("rm_rst_rv", 32'({i1.rsp_valid, i0.rsp_valid}), 32'd0);
    next();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rm_no_rsp%0d", k), 32'({i1.rsp_valid, i0.rsp_valid, busy}), 32'd0);
      next();
    end

    // Fairness: both continuously valid with op 7, responses always accepted
    drive_req(0, 1'b1, 32'd9, 32'd4, 3'd7);
    drive_req(1, 1'b1, 32'd9, 32'd4, 3'd7);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (i0.req_ready) grants.push_back(0);
      if (i1.req_ready) grants.push_back(1);
      if (i0.rsp_valid) chk_rsp(0, "fair_rsp0", 32'd0, 1'b1, 1'b0, 1'b1);
      if (i1.rsp_valid) chk_rsp(1, "fair_rsp1", 32'd0, 1'b1, 1'b0, 1'b1);
      next();
    end
    chk("fair_count", 32'(grants.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("fair_order%0d", k), (k < grants.size()) ? 32'(grants[k]) : 32'hDEAD, 32'(k % 2));
    drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
    next(); next(); next(); next();

    // Randomized traffic against the transaction model, from a fresh reset
    rst_n = 1'b0;
    next(); next();
    rst_n = 1'b1;
    m_ptr = 1'b0;
    m_age = 0;
    m_owner = 0;
    m_exp = '0;
    for (int n = 0; n < 2; n++) begin
      mv[n] = 1'b0; ma[n] = '0; mb[n] = '0; mop[n] = '0; mrr[n] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      logic [1:0] exp_rv;
      for (int n = 0; n < 2; n++) begin
        if (!mv[n]) begin
          if ($urandom_range(0, 2) == 0) begin
            mv[n]  = 1'b1;
            ma[n]  = rand_opnd();
            mb[n]  = ($urandom_range(0, 7) == 0) ? ma[n] : rand_opnd();
            mop[n] = 3'($urandom_range(0, 7));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          mv[n] = 1'b0;
        end
        mrr[n] = ($urandom_range(0, 3) != 0);
        drive_req(n, mv[n], ma[n], mb[n], mop[n]);
      end
      i0.rsp_ready = mrr[0];
      i1.rsp_ready = mrr[1];
      @(negedge clk);

      g = -1;
      if (m_age == 0) begin
        if (mv[0] && mv[1]) g = int'(m_ptr);
        else if (mv[0])     g = 0;
        else if (mv[1])     g = 1;
      end
      exp_rv = 2'b00;
      if (m_age >= 2) exp_rv[m_owner] = 1'b1;
      chk("rnd_ready0", 32'(i0.req_ready), 32'(g == 0));
      chk("rnd_ready1", 32'(i1.req_ready), 32'(g == 1));
      chk("rnd_busy", 32'(busy), 32'(m_age >= 1));
      chk("rnd_rv", 32'({i1.rsp_valid, i0.rsp_valid}), 32'(exp_rv));
      if (m_age >= 2)
        chk_rsp(m_owner, "rnd_rsp", m_exp[34:3], m_exp[2], m_exp[1], m_exp[0]);

      if (g >= 0) begin
        m_owner = g;
        m_exp   = alu_ref(ma[g], mb[g], mop[g]);
        m_ptr   = (g == 0);
        m_age   = 1;
        mv[g]   = 1'b0;
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_age >= 2) begin
        if (mrr[m_owner]) m_age = 0;
        else m_age++;
      end
      next();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
